// File: rtl/argmax_sequencer.sv
// argmax_sequencer: serial argmax over number_of_labels scores with a held label output.
// Optional max_score port enabled by defining ARGMAX_SCORE_OUT_EN.
module argmax_sequencer #(
  parameter int n = 8,
  parameter int number_of_labels = 10,
  parameter int clog2_number_of_labels = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [n-1:0]                      in_data,
  output logic                              in_ready,
  output logic                              label_valid,
  output logic [clog2_number_of_labels-1:0] label,
  input  logic                              label_ready,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [n-1:0]                      max_score,
`endif
  output logic                              busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [clog2_number_of_labels-1:0] LAST = clog2_number_of_labels'(number_of_labels - 1);
  state_t r_state;
  logic [clog2_number_of_labels-1:0] r_idx, r_best_idx;
  logic [n-1:0] r_best_val;
  logic r_in_ready, r_label_valid, r_busy;
  logic w_beat, w_last;
  assign w_beat = (r_state == SCAN) && in_valid;
  assign w_last = r_idx == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_best_idx    <= '0;
      r_best_val    <= '0;
      r_in_ready    <= 1'b0;
      r_label_valid <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idx      <= '0;
          r_best_idx <= '0;
          r_best_val <= '0;
          if (start) begin
            r_state    <= SCAN;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        SCAN: if (w_beat) begin
          // strict compare keeps the lowest index on ties
          if (in_data > r_best_val) begin
            r_best_val <= in_data;
            r_best_idx <= r_idx;
          end
          r_idx <= w_last ? r_idx : r_idx + 1'b1;
          if (w_last) begin
            r_state       <= DONE;
            r_in_ready    <= 1'b0;
            r_label_valid <= 1'b1;
          end
        end
        DONE: if (label_ready) begin
          r_state       <= IDLE;
          r_label_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready    = r_in_ready;
  assign label_valid = r_label_valid;
  assign busy        = r_busy;
  assign label       = r_best_idx;
`ifdef ARGMAX_SCORE_OUT_EN
  assign max_score   = r_best_val;
`endif
endmodule

// File: tb/tb_argmax_sequencer.sv
// tb_argmax_sequencer: directed checks of argmax_sequencer (build with ARGMAX_SCORE_OUT_EN to cover max_score).
module tb_argmax_sequencer;
  typedef logic [7:0] sc_t [10];
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0, in_valid = 1'b0, label_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic in_ready, label_valid, busy;
  logic [3:0] label;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [7:0] max_score;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0, hs_cyc = 0;

  argmax_sequencer #(.n(8), .number_of_labels(10), .clog2_number_of_labels(4)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .label_valid(label_valid), .label(label), .label_ready(label_ready),
`ifdef ARGMAX_SCORE_OUT_EN
    .max_score(max_score),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_label_valid"}, 32'(label_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_label"}, 32'(label), 0);
`ifdef ARGMAX_SCORE_OUT_EN
    chk({tag, "_max_score"}, 32'(max_score), 0);
`endif
  endtask

  task automatic async_rst(input string tag);
    #2 rst = 1'b1;
    #1 rst_chk(tag);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    label_ready = 1'b1;
  endtask

  task automatic classify(input sc_t s, input bit gaps, input int hold, input int rst_at,
                          input logic [3:0] exp_label, input bit b2b);
    int s_cyc, tries;
    int hs_prev = hs_cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    chk("scan_in_ready", 32'(in_ready), 1);
    chk("scan_busy", 32'(busy), 1);
    label_ready = (hold == 0);
    for (int i = 0; i < 10; i++) begin
      if (rst_at == i) begin
        async_rst("rst_scan");
        return;
      end
      tries = 0;
      do begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data = in_valid ? s[i] : 8'hFF;
        tries++;
        @(posedge clk); #1;
      end while (!in_valid && tries < 50);
      if (!in_valid) chk("beat_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_data = '0;
    chk("done_label_valid", 32'(label_valid), 1);
    chk("done_label", 32'(label), 32'(exp_label));
    if (!gaps) chk("start_to_label", 32'(cyc - s_cyc + 1), 11);
    if (b2b) chk("b2b_latency", 32'(cyc - hs_prev + 1), 12);
`ifdef ARGMAX_SCORE_OUT_EN
    chk("done_max_score", 32'(max_score), 32'(s[exp_label]));
`endif
    if (rst_at == 10) begin
      async_rst("rst_done");
      return;
    end
    for (int k = 0; k < hold; k++) begin
      start = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(label_valid), 1);
      chk("hold_label", 32'(label), 32'(exp_label));
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    start = 1'b0;
    label_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    chk("hs_label_valid", 32'(label_valid), 0);
    chk("hs_busy", 32'(busy), 0);
  endtask

  initial begin
    sc_t a;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sc_t a;
    #12 rst_chk("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    a = '{3, 9, 1, 0, 7, 2, 8, 4, 5, 6};
    classify(a, 0, 0, -1, 4'd1, 0);
    a = '{5, 200, 7, 200, 0, 0, 0, 0, 0, 0};
    classify(a, 0, 0, -1, 4'd1, 0);
    a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    classify(a, 0, 0, -1, 4'd0, 0);
    a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 255};
    classify(a, 0, 0, -1, 4'd9, 0);
    a = '{10, 40, 40, 3, 90, 12, 90, 1, 0, 89};
    classify(a, 1, 5, -1, 4'd4, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = '{100, 200, 150, 250, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = a[i];
      @(posedge clk); #1;
    end
    clear = 1'b1;
    in_data = 8'd250;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_label", 32'(label), 0);
    a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 50};
    classify(a, 0, 0, -1, 4'd9, 0);
    a = '{3, 9, 1, 0, 7, 2, 8, 4, 5, 6};
    classify(a, 0, 0, 6, 4'd1, 0);
    classify(a, 0, 0, -1, 4'd1, 0);
    a = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 8};
    classify(a, 0, 0, 10, 4'd9, 0);
    classify(a, 0, 0, -1, 4'd9, 0);
    a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    classify(a, 0, 0, -1, 4'd9, 0);
    a = '{50, 49, 48, 47, 46, 45, 44, 43, 42, 41};
    classify(a, 0, 0, -1, 4'd0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/argmax_sequencer.md
# argmax_sequencer

Sequential argmax controller for the classifier output stage. It accepts the output-layer neuron scores one per cycle over a valid/ready stream and tracks the running maximum and its index. It then presents the winning class index on a held valid/ready output port. It replaces the wide all-scores-in-parallel comparison with a single n-bit comparator, so the last MLP layer can drain its neurons serially.

## Interface
Parameters:
- `n`, 8, score width in bits (unsigned)
- `number_of_labels`, 10, scores per classification
- `clog2_number_of_labels`, 4, width of label/index; must satisfy 2^w ≥ number_of_labels

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a new classification (sampled only in IDLE)
- `clear`  in  1  synchronous abort; returns to IDLE from any state
- `in_valid`  in  1  `in_data` holds a score
- `in_data`  in  n  score, unsigned
- `in_ready`  out  1  block accepts a score this cycle
- `label_valid`  out  1  `label` is final
- `label`  out  clog2_number_of_labels  index of maximum score
- `label_ready`  in  1  consumer takes `label`
- `busy`  out  1  high in SCAN or DONE
- `max_score`  out  n  winning score (only with ARGMAX_SCORE_OUT_EN)

## Operation
- States: IDLE, SCAN, DONE. Reset state is IDLE.
- Registers: `idx` (score counter), `best_val` (n bits), `best_idx`.
- IDLE:
  - `start` = 1 → SCAN
  - `idx`, `best_val`, and `best_idx` cleared to 0.
- SCAN:
  - `in_ready` = 1.
  - Beat accepted when `in_valid && in_ready`.
  - On an accepted beat, if `in_data > best_val` (strict, unsigned), then `best_val` ← `in_data` and `best_idx` ← `idx`.
  - `idx` increments on each accepted beat.
  - Accepting the beat with `idx == number_of_labels-1` → DONE. The comparison for that beat is included.
- DONE:
  - `label_valid` = 1.
  - `label` = `best_idx`, stable until handshake.
  - `label_valid && label_ready` → IDLE.
- Tie rule: the first (lowest) index holding the maximum wins. All-zero scores give label 0.
- `in_valid` low in SCAN stalls; no state changes.
- `start` outside IDLE is ignored.
- `clear` has priority over every other transition. It forces IDLE and clears `idx`/`best_*` on the next edge. A handshake in the same cycle is discarded.
- `in_data` is ignored when `in_ready` = 0.

## Timing
- Reset values:
  - `in_ready` = 0, `label_valid` = 0, `label` = 0, `busy` = 0, `max_score` = 0.
  - State IDLE.
- `in_ready` is a registered-state decode: high the cycle after `start` is sampled.
- Latency:
  - Last score accepted at edge k → `label_valid` high in cycle k+1.
  - Minimum start-to-label: `number_of_labels`+1 cycles.
- Zero-bubble back-to-back:
  - Label handshake at edge j → IDLE in cycle j+1.
  - `start` sampled there → SCAN in cycle j+2.
- `label` is driven from `best_idx` in all states. It is meaningful only while `label_valid` = 1.
- `rst` assertion mid-SCAN or mid-DONE immediately (asynchronously) returns all outputs to reset values. A partial scan is lost.
- Counter never wraps: the DONE transition occurs at `number_of_labels-1`.

## Configuration
- Macro: `ARGMAX_SCORE_OUT_EN`.
- Defined:
  - `max_score` port exists and is driven from `best_val`.
  - It is held with `label` during DONE.
- Undefined:
  - Port absent.
  - `best_val` still internal; functional behavior otherwise identical.

## Test plan
- Basic: after reset, `start`, stream 3,9,1,0,7,2,8,4,5,6 with `in_valid` continuous, `label_ready` = 1. Required:
  - `label_valid` pulse 11 cycles after `start` sampled, with `label` = 1.
  - With macro: `max_score` = 9.
- Ties/zeros:
  - Stream 5,200,7,200,0,0,0,0,0,0 → `label` = 1.
  - All zeros → `label` = 0.
  - Stream 255 only at index 9 → `label` = 9.
- Backpressure: random `in_valid` gaps and `label_ready` held low 5 cycles. Required:
  - `label` and `label_valid` stable throughout the hold.
  - IDLE the cycle after `label_ready` rises.
- Abort: `clear` after 4 beats, then new `start` with 0,0,0,0,0,0,0,0,0,50. Required:
  - `label` = 9.
  - No residue from the aborted scan.
- Reset mid-operation: assert `rst` asynchronously (between edges) during SCAN beat 6 and during DONE. Required:
  - Outputs return to reset values without a clock edge.
  - Next full scan is correct.
- Back-to-back: two classifications with `start` asserted in the IDLE cycle right after the first handshake. Required:
  - Second `label_valid` exactly 12 cycles after the first handshake.
  - Both labels correct.
